// File: rtl/axis_corr_peak.sv
// Per-window peak detector: |lane| reduction, running max, one {found, index, magnitude} word per window.
// Result valid 2 clocks after the last window beat; input stalls only while a result is held unaccepted.
module axis_corr_peak #(
   parameter int NUM_PARALLEL = 8,
   parameter int LANE_WIDTH   = 16,
   parameter int WINDOW_BEATS = 64,
   parameter int INDEX_WIDTH  = $clog2(NUM_PARALLEL * WINDOW_BEATS),
   parameter int OUT_WIDTH    = 1 + INDEX_WIDTH + LANE_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [LANE_WIDTH-1:0]              threshold,
   input  logic                               restart,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic [NUM_PARALLEL*LANE_WIDTH-1:0] s_axis_tdata,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic [OUT_WIDTH-1:0]               m_axis_tdata
);

   localparam int LB = $clog2(NUM_PARALLEL);
   localparam int BB = $clog2(WINDOW_BEATS);

   logic                  en, acc;
   logic [BB-1:0]         beat_cur;
   logic [LANE_WIDTH-1:0] thr_cur;
   logic [LANE_WIDTH-1:0] lane;
   logic [LANE_WIDTH-1:0] tm [NUM_PARALLEL];
   logic [LB-1:0]         ti [NUM_PARALLEL];

   logic [BB-1:0]          cnt_q, cnt_d;
   logic [LANE_WIDTH-1:0]  thr_q, thr_d;
   logic                   s1_vld_q, s1_vld_d;
   logic [BB-1:0]          s1_beat_q, s1_beat_d;
   logic [LANE_WIDTH-1:0]  s1_mag_q, s1_mag_d;
   logic [LB-1:0]          s1_lane_q, s1_lane_d;
   logic [LANE_WIDTH-1:0]  s1_thr_q, s1_thr_d;
   logic                   s2_last_q, s2_last_d;
   logic [LANE_WIDTH-1:0]  s2_thr_q, s2_thr_d;
   logic [LANE_WIDTH-1:0]  pk_mag_q, pk_mag_d;
   logic [INDEX_WIDTH-1:0] pk_idx_q, pk_idx_d;
   logic                   out_vld_q, out_vld_d;
   logic [OUT_WIDTH-1:0]   out_dat_q, out_dat_d;

   assign en            = ~(out_vld_q & ~m_axis_tready);
   assign acc           = en & s_axis_tvalid;
   assign s_axis_tready = en;
   assign m_axis_tvalid = out_vld_q;
   assign m_axis_tdata  = out_dat_q;

   // A restart beat is forced to beat 0 so it opens the new window and latches threshold.
   assign beat_cur = restart ? '0 : cnt_q;
   assign thr_cur  = (beat_cur == '0) ? threshold : thr_q;

   // Saturated magnitudes, then a pairwise tree where strict > keeps the lower lane on ties.
   always_comb begin
      lane = '0;
      for (int i = 0; i < NUM_PARALLEL; i++) begin
         lane = s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH];
         if (lane == {1'b1, {(LANE_WIDTH-1){1'b0}}})
            tm[i] = {1'b0, {(LANE_WIDTH-1){1'b1}}};
         else if (lane[LANE_WIDTH-1])
            tm[i] = -lane;
         else
            tm[i] = lane;
         ti[i] = LB'(i);
      end
      for (int l = 0; l < LB; l++) begin
         for (int i = 0; i < NUM_PARALLEL; i += (2 << l)) begin
            if (tm[i + (1 << l)] > tm[i]) begin
               tm[i] = tm[i + (1 << l)];
               ti[i] = ti[i + (1 << l)];
            end
         end
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      thr_d     = thr_q;
      s1_vld_d  = s1_vld_q;
      s1_beat_d = s1_beat_q;
      s1_mag_d  = s1_mag_q;
      s1_lane_d = s1_lane_q;
      s1_thr_d  = s1_thr_q;
      s2_last_d = s2_last_q;
      s2_thr_d  = s2_thr_q;
      pk_mag_d  = pk_mag_q;
      pk_idx_d  = pk_idx_q;
      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;

      if (restart) begin
         cnt_d     = '0;
         s1_vld_d  = 1'b0;
         s2_last_d = 1'b0;
      end

      if (en) begin
         if (acc) begin
            cnt_d = beat_cur + 1'b1;
            thr_d = thr_cur;
         end
         s1_vld_d  = acc;
         s1_beat_d = beat_cur;
         s1_mag_d  = tm[0];
         s1_lane_d = ti[0];
         s1_thr_d  = thr_cur;

         s2_last_d = s1_vld_q & ~restart & (s1_beat_q == BB'(WINDOW_BEATS-1));
         if (s1_vld_q & ~restart) begin
            if ((s1_beat_q == '0) || (s1_mag_q > pk_mag_q)) begin
               pk_mag_d = s1_mag_q;
               pk_idx_d = {s1_beat_q, s1_lane_q};
            end
            s2_thr_d = s1_thr_q;
         end

         // Output slot is free or being drained this edge, so it simply follows stage 2.
         out_vld_d = s2_last_q & ~restart;
         if (s2_last_q & ~restart)
            out_dat_d = {(pk_mag_q > s2_thr_q), pk_idx_q, pk_mag_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         thr_q     <= '0;
         s1_vld_q  <= 1'b0;
         s1_beat_q <= '0;
         s1_mag_q  <= '0;
         s1_lane_q <= '0;
         s1_thr_q  <= '0;
         s2_last_q <= 1'b0;
         s2_thr_q  <= '0;
         pk_mag_q  <= '0;
         pk_idx_q  <= '0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         thr_q     <= thr_d;
         s1_vld_q  <= s1_vld_d;
         s1_beat_q <= s1_beat_d;
         s1_mag_q  <= s1_mag_d;
         s1_lane_q <= s1_lane_d;
         s1_thr_q  <= s1_thr_d;
         s2_last_q <= s2_last_d;
         s2_thr_q  <= s2_thr_d;
         pk_mag_q  <= pk_mag_d;
         pk_idx_q  <= pk_idx_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
      end
   end

endmodule
